// File: rtl/change_dispenser.sv
// Greedy coin-change issuer: takes a change amount and hands out 25/10/5 coin
// codes one per valid/ready handshake, then pulses done with count and residue.
module change_dispenser #(
   parameter int AMT_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [AMT_W-1:0] amount_i,
   output logic             coin_valid_o,
   output logic [1:0]       coin_sel_o,
   input  logic             coin_ready_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] coin_cnt_o,
   output logic [AMT_W-1:0] remain_o,
   output logic [1:0]       state_dbg_o
);

   // Handshake: a coin transfers on a rising clk_i edge where coin_valid_o and
   // coin_ready_i are both high; valid and sel hold steady until that edge.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DISP = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [AMT_W-1:0] VAL_5  = AMT_W'(5);
   localparam logic [AMT_W-1:0] VAL_10 = AMT_W'(10);
   localparam logic [AMT_W-1:0] VAL_25 = AMT_W'(25);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_e           state_q, state_d;
   logic [AMT_W-1:0] remain_q, remain_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0]       sel;
   logic [AMT_W-1:0] sel_val;
   logic             offer;

   // Selection depends only on registered remain, so the offer cannot change
   // until the coin is accepted.
   always_comb begin
      sel     = 2'b00;
      sel_val = '0;
      if (remain_q >= VAL_25) begin
         sel     = 2'b11;
         sel_val = VAL_25;
      end else if (remain_q >= VAL_10) begin
         sel     = 2'b10;
         sel_val = VAL_10;
      end else if (remain_q >= VAL_5) begin
         sel     = 2'b01;
         sel_val = VAL_5;
      end
   end

   assign offer = (state_q == DISP) && (sel != 2'b00);

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               remain_d = amount_i;
               cnt_d    = '0;
               state_d  = DISP;
            end
         end
         DISP: begin
            if (!offer) begin
               state_d = DONE;
            end else if (coin_ready_i) begin
               remain_d = remain_q - sel_val;
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         remain_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         cnt_q    <= cnt_d;
      end
   end

   assign coin_valid_o = offer;
   assign coin_sel_o   = offer ? sel : 2'b00;
   assign busy_o       = (state_q != IDLE);
   assign done_o       = (state_q == DONE);
   assign coin_cnt_o   = cnt_q;
   assign remain_o     = remain_q;
   assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: table of change runs with hand-computed
// coin sequences and latencies, plus reset-mid-run and held-start sequences.
module tb_change_dispenser;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] amount;
   logic       coin_valid;
   logic [1:0] coin_sel;
   logic       coin_ready;
   logic       busy;
   logic       done;
   logic [7:0] coin_cnt;
   logic [7:0] remain;
   logic [1:0] state_dbg;

   int checks;
   int failures;

   change_dispenser #(.AMT_W(8), .CNT_W(8)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .amount_i     (amount),
      .coin_valid_o (coin_valid),
      .coin_sel_o   (coin_sel),
      .coin_ready_i (coin_ready),
      .busy_o       (busy),
      .done_o       (done),
      .coin_cnt_o   (coin_cnt),
      .remain_o     (remain),
      .state_dbg_o  (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  amount;
      int          ready_mode;   // 0: ready always high, 1: high in odd cycles
      bit          inject;       // pulse start with amount 99 in cycle 1
      int          exp_n;
      logic [21:0] exp_codes;    // coin 1 in bits [1:0]
      int          exp_done;
      logic [7:0]  exp_cnt;
      logic [7:0]  exp_remain;
   } vec_t;

   vec_t vecs[11];
   logic [1:0] got_q[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"},  int'(coin_valid), 0);
      check({tag, "_sel"},    int'(coin_sel),   0);
      check({tag, "_busy"},   int'(busy),       0);
      check({tag, "_done"},   int'(done),       0);
      check({tag, "_cnt"},    int'(coin_cnt),   0);
      check({tag, "_remain"}, int'(remain),     0);
      check({tag, "_state"},  int'(state_dbg),  0);
   endtask

   // Starts a run and follows it cycle by cycle until done_o or a timeout.
   task automatic run_case(input int idx, input vec_t v);
      int         k;
      int         done_cyc;
      bit         busy_bad;
      bit         pending;
      logic [1:0] pend_sel;
      logic [1:0] exp_code;
      got_q.delete();
      done_cyc = -1;
      busy_bad = 1'b0;
      pending  = 1'b0;
      pend_sel = 2'b00;
      @(negedge clk);
      start  = 1'b1;
      amount = v.amount;
      @(posedge clk);
      for (k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check($sformatf("v%0d_capture", idx), int'(remain), int'(v.amount));
            start  = v.inject;
            amount = v.inject ? 8'd99 : 8'd0;
         end else begin
            start  = 1'b0;
            amount = 8'd0;
         end
         coin_ready = (v.ready_mode == 0) ? 1'b1 : ((k % 2) == 1);
         if (!busy) busy_bad = 1'b1;
         if (pending) begin
            check($sformatf("v%0d_hold_c%0d", idx, k), int'({coin_valid, coin_sel}),
                  int'({1'b1, pend_sel}));
         end
         if (!coin_valid && coin_sel != 2'b00) begin
            check($sformatf("v%0d_sel_idle_c%0d", idx, k), int'(coin_sel), 0);
         end
         if (coin_valid && coin_ready) got_q.push_back(coin_sel);
         pending  = coin_valid && !coin_ready;
         pend_sel = coin_sel;
         if (done) begin
            done_cyc = k;
            break;
         end
      end
      coin_ready = 1'b0;
      check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
      check($sformatf("v%0d_busy_run", idx), int'(busy_bad), 0);
      check($sformatf("v%0d_ncoins", idx), got_q.size(), v.exp_n);
      for (int i = 0; i < v.exp_n && i < got_q.size(); i++) begin
         exp_code = v.exp_codes[2*i +: 2];
         check($sformatf("v%0d_code%0d", idx, i + 1), int'(got_q[i]), int'(exp_code));
      end
      check($sformatf("v%0d_cnt", idx), int'(coin_cnt), int'(v.exp_cnt));
      check($sformatf("v%0d_remain", idx), int'(remain), int'(v.exp_remain));
      @(negedge clk);
      check($sformatf("v%0d_idle_busy", idx), int'(busy), 0);
      check($sformatf("v%0d_hold_cnt", idx), int'(coin_cnt), int'(v.exp_cnt));
      check($sformatf("v%0d_hold_remain", idx), int'(remain), int'(v.exp_remain));
   endtask

   initial begin
      vec_t r;
      checks     = 0;
      failures   = 0;
      rst_n      = 1'b0;
      start      = 1'b0;
      amount     = 8'd0;
      coin_ready = 1'b0;

      //          amount mode inj  n  codes (coin1 lowest)       done cnt rem
      vecs[0]  = '{8'd40,  0, 1'b0, 3, 22'b01_10_11,               5, 8'd3,  8'd0};
      vecs[1]  = '{8'd3,   0, 1'b0, 0, 22'b0,                      2, 8'd0,  8'd3};
      vecs[2]  = '{8'd255, 1, 1'b0, 11,
                   22'b01_11_11_11_11_11_11_11_11_11_11,          23, 8'd11, 8'd0};
      vecs[3]  = '{8'd34,  0, 1'b0, 2, 22'b01_11,                  4, 8'd2,  8'd4};
      vecs[4]  = '{8'd30,  0, 1'b1, 2, 22'b01_11,                  4, 8'd2,  8'd0};
      vecs[5]  = '{8'd0,   0, 1'b0, 0, 22'b0,                      2, 8'd0,  8'd0};
      vecs[6]  = '{8'd4,   0, 1'b0, 0, 22'b0,                      2, 8'd0,  8'd4};
      vecs[7]  = '{8'd5,   0, 1'b0, 1, 22'b01,                     3, 8'd1,  8'd0};
      vecs[8]  = '{8'd24,  0, 1'b0, 2, 22'b10_10,                  4, 8'd2,  8'd4};
      vecs[9]  = '{8'd25,  0, 1'b0, 1, 22'b11,                     3, 8'd1,  8'd0};
      vecs[10] = '{8'd40,  1, 1'b0, 3, 22'b01_10_11,               7, 8'd3,  8'd0};

      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) run_case(i, vecs[i]);

      // Reset during the second coin of a 60-cent run.
      @(negedge clk);
      start      = 1'b1;
      amount     = 8'd60;
      coin_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("rst60_c1_sel", int'(coin_sel), 3);
      @(negedge clk);
      coin_ready = 1'b0;
      check("rst60_c2_valid", int'({coin_valid, coin_sel}), int'({1'b1, 2'b11}));
      check("rst60_c2_cnt", int'(coin_cnt), 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst60");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      r = '{8'd10, 0, 1'b0, 1, 22'b10, 3, 8'd1, 8'd0};
      run_case(11, r);

      // start held high through DONE: the next run begins at the IDLE edge
      // and samples amount_i there.
      @(negedge clk);
      start      = 1'b1;
      amount     = 8'd5;
      coin_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("held_c1_sel", int'({coin_valid, coin_sel}), int'({1'b1, 2'b01}));
      @(negedge clk);
      check("held_c2_valid", int'(coin_valid), 0);
      @(negedge clk);
      check("held_c3_done", int'(done), 1);
      amount = 8'd10;
      @(negedge clk);
      check("held_c4_idle", int'({busy, done}), 0);
      check("held_c4_remain", int'(remain), 0);
      @(negedge clk);
      check("held_c5_sel", int'({coin_valid, coin_sel}), int'({1'b1, 2'b10}));
      check("held_c5_cnt", int'(coin_cnt), 0);
      start = 1'b0;
      @(negedge clk);
      check("held_c6_remain", int'(remain), 0);
      check("held_c6_cnt", int'(coin_cnt), 1);
      @(negedge clk);
      check("held_c7_done", int'(done), 1);
      coin_ready = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Sequential coin-change issuer for the vending datapath. It is the inverse of the coin-select decoder, which maps 2-bit codes to values 0/5/10/25. This block takes a change amount and emits a greedy sequence of 2-bit coin codes to the coin-ejector mechanism, one coin per valid/ready handshake. When done it reports the coin count and any residue too small to dispense.

## Interface
Parameters:
- AMT_W, 8, width of amount and residue (unsigned cents).
- CNT_W, 8, width of the dispensed-coin counter.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  request a change run; sampled only in IDLE.
- amount_i  in  AMT_W  change amount; captured on the accepted start_i edge.
- coin_valid_o  out  1  a coin is offered on coin_sel_o.
- coin_sel_o  out  2  coin code: 2'b01 = 5, 2'b10 = 10, 2'b11 = 25; 2'b00 (value 0) whenever coin_valid_o = 0.
- coin_ready_i  in  1  ejector accepts the offered coin.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse at run completion.
- coin_cnt_o  out  CNT_W  coins dispensed in the current/last run.
- remain_o  out  AMT_W  remaining amount; after done_o it holds the undispensable residue (always < 5).

## Operation
- Registered state: FSM {IDLE, DISP, DONE}, remain register (AMT_W), cnt register (CNT_W).
- IDLE: when start_i = 1, load remain <= amount_i and cnt <= 0, then go to DISP. start_i is ignored in DISP and DONE; no queuing.
- DISP, greedy selection from the registered remain:
  - remain >= 25: code 11.
  - else remain >= 10: code 10.
  - else remain >= 5: code 01.
  - else: no coin.
- DISP with remain >= 5: coin_valid_o = 1. On coin_valid_o & coin_ready_i, remain <= remain - value and cnt <= cnt + 1. Stay in DISP.
- DISP with remain < 5: coin_valid_o = 0 and coin_sel_o = 00. Go to DONE.
- DONE: done_o = 1 for this cycle only, then go to IDLE. remain_o and coin_cnt_o hold their values until the next accepted start.
- coin_valid_o, coin_sel_o and done_o are decoded combinationally from the registered state and remain. They are glitch-free relative to clk_i and never depend combinationally on coin_ready_i.
- Arithmetic: remain is unsigned and the subtraction never underflows, because the selected value is always <= remain. cnt saturates at all-ones; it cannot saturate for AMT_W = 8, where the maximum is 11 coins.

## Timing
- Reset values: state = IDLE, remain_o = 0, coin_cnt_o = 0, coin_valid_o = 0, coin_sel_o = 00, busy_o = 0, done_o = 0.
- Reset asserted mid-run: the FSM drops to IDLE immediately (asynchronously), and coin_valid_o falls without waiting for a handshake.
- Handshake rule: once coin_valid_o rises, coin_valid_o and coin_sel_o stay stable until the cycle in which coin_ready_i = 1. This holds by construction, because remain changes only on accept.
- coin_ready_i is a don't-care while coin_valid_o = 0.
- Latency with coin_ready_i held high, where N = number of coins:
  - Start accepted at edge E0.
  - Coin k (k = 1..N) is presented in cycle k and accepted at edge Ek.
  - One DISP cycle follows with valid low.
  - done_o is high in cycle N+2. busy_o is high in cycles 1 through N+2.
- Each cycle of coin_ready_i = 0 while valid is high delays every later event by exactly one cycle.
- amount_i < 5: no coin is offered. done_o is high in cycle 2 and remain_o = amount_i.
- start_i held high through DONE into IDLE: a new run starts at the IDLE edge, and amount_i is re-sampled at that edge.

## Test plan
- amount 40, ready always 1 -> codes 11, 10, 01 in cycles 1-3; done_o in cycle 5; coin_cnt_o = 3; remain_o = 0.
- amount 3 -> coin_valid_o never high; done_o in cycle 2; coin_cnt_o = 0; remain_o = 3.
- amount 255, ready toggling 1010... -> 10× code 11 then 1× code 01, with codes stable while ready = 0; coin_cnt_o = 11; remain_o = 0.
- amount 34 -> codes 11, 01; coin_cnt_o = 2; remain_o = 4.
- start_i pulsed with amount 99 while busy on a run of 30 -> ignored; the run yields 11, 01 and remain_o = 0.
- rst_ni low during the second coin of amount 60 -> outputs return to reset values in the same cycle. After release, a start with amount 10 yields a single code 10.
